ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one single-port synchronous RAM between two requesters.
  - Port A: the SPI command side, i.e. the decoded SPI slave frames.
  - Port B: a local host/DMA side.
- Each port uses a req/gnt handshake. Winners are picked by round-robin or fixed priority, then issued to the RAM through registered outputs.
- Read data is routed back to the winning port with a pulse-qualified valid.
- The block sits between the SPI frame decoder, the host logic and the RAM instance.

Parameters:
- ADDR_SIZE, 8, RAM address width.
- WORD_SIZE, 8, RAM data width.
- ARB_MODE, 0, 0 = round-robin; 1 = fixed priority, port A always wins.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- a_req  in  1  port A request; held high with fields stable until a_gnt
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  ADDR_SIZE  port A address
- a_wdata  in  WORD_SIZE  port A write data
- a_gnt  out  1  one-cycle pulse: port A access issued this cycle
- a_rvalid  out  1  one-cycle pulse: a_rdata valid (reads only)
- a_rdata  out  WORD_SIZE  port A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for port B
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_SIZE  RAM address
- mem_wdata  out  WORD_SIZE  RAM write data
- mem_rdata  in  WORD_SIZE  RAM read data; valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset values:
  - All outputs 0: gnt, rvalid, mem_en, mem_we, mem_addr, mem_wdata.
  - FSM in IDLE.
  - Round-robin pointer last_grant = B, so port A wins the first tie.
- FSM states:
  - IDLE:
    - If any req is high, select a winner and go to ISSUE.
    - Register at the edge: mem_en=1, mem_we/mem_addr/mem_wdata from the winner, winner's gnt=1, sel_reg=winner.
    - Otherwise stay in IDLE with mem_en=0.
  - ISSUE: lasts exactly one cycle.
    - mem_en and gnt are high during this cycle.
    - Both req inputs are ignored; the granted requester only drops or changes req at the next edge.
    - Next state is always IDLE. mem_en and gnt return to 0.
- Throughput and latency:
  - At most one access per 2 cycles.
  - Grant latency is 1 cycle from req seen in IDLE.
- Read return:
  - If the ISSUE access was a read, then in the following cycle <sel>_rvalid=1 for one cycle.
  - <sel>_rdata is driven combinationally from mem_rdata.
  - The non-selected port's rvalid stays 0.
  - Both rdata outputs mirror mem_rdata at all times; only the rvalid qualification differs.
- Writes: gnt only, no rvalid.
- Winner selection:
  - ARB_MODE=0, both requesting: the port other than last_grant wins.
  - ARB_MODE=0, one requesting: that port wins.
  - ARB_MODE=1: A always wins when a_req=1.
  - last_grant updates on every issue in both modes.
- Simultaneous events:
  - A read-return cycle coincides with IDLE, so a new arbitration can occur in the same cycle as rvalid.
  - The rvalid routing uses the registered sel of the previous access, never the new winner.
- A req deasserted before grant is treated as withdrawn. No memory access occurs and no error is raised.
- Reset mid-operation:
  - rst during ISSUE or the read-return cycle clears everything at that edge.
  - The pending rvalid is suppressed.
  - The RAM access already presented is not cancelled; this is acceptable because it is RAM-side.
- Starvation: in ARB_MODE=0 with both ports continuously requesting, grants strictly alternate A,B,A,B.

Decomposition:
- Package ram_arb_pkg holds:
  - state encoding (IDLE, ISSUE);
  - port index constants (PORT_A=0, PORT_B=1);
  - ARB_MODE encodings (ARB_RR=0, ARB_FIXED=1).
- One sub-module, arb_prio_select: combinational winner selection.
  - Inputs: req[1:0], last_grant, mode.
  - Outputs: winner, any_req.
- FSM, issue registers and read-return routing stay in ram_port_arbiter.

Test Plan:
- Single A write: a_req=1, a_we=1, a_addr=0x10, a_wdata=0xA5 → next cycle mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xA5, a_gnt=1; b_gnt=0; no rvalid.
- Single B read after that write: b_req=1, b_we=0, b_addr=0x10 → b_gnt at issue; one cycle later b_rvalid=1, b_rdata=0xA5, a_rvalid=0.
- Contention, ARB_MODE=0: a_req and b_req held for 8 cycles from reset → grants A,B,A,B on cycles 1,3,5,7; mem_en never high on two consecutive cycles.
- Contention, ARB_MODE=1: both held → only a_gnt pulses; b_gnt=0 until a_req drops, then b_gnt on the next issue.
- Overlap: A read of 0x20 (RAM 0x3C) then immediate B request → a_rvalid=1 with 0x3C in the same cycle B is arbitrated; b_gnt the cycle after; no rvalid on B for a B write.
- Reset mid-read: assert rst in the ISSUE cycle of an A read → a_rvalid stays 0; all outputs 0; first post-reset tie is won by A.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter:
// FSM encoding, port indices and arbitration mode codes.
package ram_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

endpackage

// File: rtl/arb_prio_select.sv
// Combinational winner pick for two requesters.
// req[1:0] (bit PORT_B = B), last_grant, mode (1 = A fixed) -> winner, any_req.
module arb_prio_select
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       mode,
  output logic       winner,
  output logic       any_req
);

  logic both;

  always_comb begin
    both    = &req;
    any_req = |req;
    winner  = PORT_A;
    unique case (1'b1)
      (!both && req[PORT_B]): winner = PORT_B;
      (both && mode):         winner = PORT_A;
      // Tie in round-robin: hand the grant to the
      // port that did not get the previous one.
      (both && !mode):        winner = ~last_grant;
      default:                winner = PORT_A;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port sync RAM between port A (SPI) and port B (host).
// Ports: a_/b_ req/we/addr/wdata in, gnt/rvalid/rdata out; mem_* to the RAM.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int WORD_SIZE = 8,
  parameter int ARB_MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [WORD_SIZE-1:0] a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [WORD_SIZE-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [WORD_SIZE-1:0] b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [WORD_SIZE-1:0] b_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam logic FIXED_MODE = (ARB_MODE == ARB_FIXED);

  state_e               state_q, state_d;
  logic                 last_q, last_d;
  logic                 sel_q, sel_d;
  logic                 rd_q, rd_d;
  logic                 en_q, en_d;
  logic                 we_q, we_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 a_gnt_q, a_gnt_d;
  logic                 b_gnt_q, b_gnt_d;
  logic                 a_rv_q, a_rv_d;
  logic                 b_rv_q, b_rv_d;

  logic winner;
  logic any_req;

  arb_prio_select u_sel (
    .req        ({b_req, a_req}),
    .last_grant (last_q),
    .mode       (FIXED_MODE),
    .winner     (winner),
    .any_req    (any_req)
  );

  always_comb begin
    state_d = IDLE;
    last_d  = last_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    a_gnt_d = 1'b0;
    b_gnt_d = 1'b0;
    a_rv_d  = 1'b0;
    b_rv_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ISSUE;
          en_d    = 1'b1;
          sel_d   = winner;
          last_d  = winner;
          if (winner == PORT_B) begin
            we_d    = b_we;
            addr_d  = b_addr;
            wdata_d = b_wdata;
            b_gnt_d = 1'b1;
            rd_d    = ~b_we;
          end else begin
            we_d    = a_we;
            addr_d  = a_addr;
            wdata_d = a_wdata;
            a_gnt_d = 1'b1;
            rd_d    = ~a_we;
          end
        end
      end
      ISSUE: begin
        // RAM data lands next cycle; route it by the
        // access just issued, not by any new winner.
        state_d = IDLE;
        a_rv_d  = rd_q && (sel_q == PORT_A);
        b_rv_d  = rd_q && (sel_q == PORT_B);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= PORT_B;
      sel_q   <= PORT_A;
      rd_q    <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
      a_rv_q  <= 1'b0;
      b_rv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      a_gnt_q <= a_gnt_d;
      b_gnt_q <= b_gnt_d;
      a_rv_q  <= a_rv_d;
      b_rv_q  <= b_rv_d;
    end
  end

  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign a_gnt     = a_gnt_q;
  assign b_gnt     = b_gnt_q;
  assign a_rvalid  = a_rv_q;
  assign b_rvalid  = b_rv_q;
  assign a_rdata   = mem_rdata;
  assign b_rdata   = mem_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter.
// Instance 0 is round-robin, instance 1 is fixed priority.
module tb_ram_port_arbiter;

  typedef struct {
    int         d;
    int         port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } iss_t;

  typedef struct {
    int         d;
    int         port;
    logic [7:0] data;
  } rd_t;

  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [1:0] a_req, a_we, a_gnt, a_rvalid;
  logic [1:0] b_req, b_we, b_gnt, b_rvalid;
  logic [1:0] mem_en, mem_we;
  logic [7:0] a_addr [2];
  logic [7:0] a_wdata [2];
  logic [7:0] a_rdata [2];
  logic [7:0] b_addr [2];
  logic [7:0] b_wdata [2];
  logic [7:0] b_rdata [2];
  logic [7:0] mem_addr [2];
  logic [7:0] mem_wdata [2];
  logic [7:0] mem_rdata [2];

  iss_t iss_q [$];
  rd_t  rd_q [$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] ram [256];
    logic       en_prev = 1'b0;

    ram_port_arbiter #(
      .ADDR_SIZE (8),
      .WORD_SIZE (8),
      .ARB_MODE  (g)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .a_req     (a_req[g]),
      .a_we      (a_we[g]),
      .a_addr    (a_addr[g]),
      .a_wdata   (a_wdata[g]),
      .a_gnt     (a_gnt[g]),
      .a_rvalid  (a_rvalid[g]),
      .a_rdata   (a_rdata[g]),
      .b_req     (b_req[g]),
      .b_we      (b_we[g]),
      .b_addr    (b_addr[g]),
      .b_wdata   (b_wdata[g]),
      .b_gnt     (b_gnt[g]),
      .b_rvalid  (b_rvalid[g]),
      .b_rdata   (b_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );

    always @(posedge clk) begin
      if (mem_en[g]) begin
        if (mem_we[g]) ram[mem_addr[g]] <= mem_wdata[g];
        else mem_rdata[g] <= ram[mem_addr[g]];
      end
    end

    always @(negedge clk) begin
      iss_t e;
      rd_t  r;
      if (mem_en[g]) begin
        check("en_gap", {31'd0, en_prev}, 0);
        check("iss_pend", {31'd0, iss_q.size() != 0}, 1);
        if (iss_q.size() != 0) begin
          e = iss_q.pop_front();
          check("iss_dut", g, e.d);
          check("gnt", {30'd0, b_gnt[g], a_gnt[g]},
                (e.port == 1) ? 2 : 1);
          check("mem_we", {31'd0, mem_we[g]}, {31'd0, e.we});
          check("mem_addr", {24'd0, mem_addr[g]}, {24'd0, e.addr});
          check("mem_wdata", {24'd0, mem_wdata[g]},
                {24'd0, e.wdata});
        end
      end else begin
        check("gnt_idle", {30'd0, b_gnt[g], a_gnt[g]}, 0);
      end
      en_prev = mem_en[g];
      if (a_rvalid[g] || b_rvalid[g]) begin
        check("rd_pend", {31'd0, rd_q.size() != 0}, 1);
        if (rd_q.size() != 0) begin
          r = rd_q.pop_front();
          check("rd_dut", g, r.d);
          check("rvalid", {30'd0, b_rvalid[g], a_rvalid[g]},
                (r.port == 1) ? 2 : 1);
          check("rdata",
                {24'd0, (r.port == 1) ? b_rdata[g] : a_rdata[g]},
                {24'd0, r.data});
        end
      end
    end
  end

  function automatic logic gnt_of(input int d, input int p);
    return (p == 1) ? b_gnt[d] : a_gnt[d];
  endfunction

  task automatic drive(input int d, input int p, input logic req,
                       input logic we, input logic [7:0] addr,
                       input logic [7:0] wd);
    if (p == 1) begin
      b_req[d] = req; b_we[d] = we;
      b_addr[d] = addr; b_wdata[d] = wd;
    end else begin
      a_req[d] = req; a_we[d] = we;
      a_addr[d] = addr; a_wdata[d] = wd;
    end
  endtask

  task automatic push_iss(input int d, input int p, input logic we,
                          input logic [7:0] addr,
                          input logic [7:0] wd);
    iss_t e;
    e.d = d; e.port = p; e.we = we; e.addr = addr; e.wdata = wd;
    iss_q.push_back(e);
  endtask

  task automatic push_rd(input int d, input int p,
                         input logic [7:0] data);
    rd_t r;
    r.d = d; r.port = p; r.data = data;
    rd_q.push_back(r);
  endtask

  task automatic do_req(input int d, input int p, input logic we,
                        input logic [7:0] addr, input logic [7:0] wd,
                        input logic [7:0] rdat);
    int n;
    push_iss(d, p, we, addr, wd);
    if (!we) push_rd(d, p, rdat);
    @(posedge clk); #1;
    drive(d, p, 1'b1, we, addr, wd);
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt_of(d, p) && n < 8);
    check("gnt_lat", n, 1);
    @(posedge clk); #1;
    drive(d, p, 1'b0, we, addr, wd);
  endtask

  task automatic check_zero(input int d);
    check("z_en", {31'd0, mem_en[d]}, 0);
    check("z_we", {31'd0, mem_we[d]}, 0);
    check("z_addr", {24'd0, mem_addr[d]}, 0);
    check("z_wdata", {24'd0, mem_wdata[d]}, 0);
    check("z_gnt", {30'd0, b_gnt[d], a_gnt[d]}, 0);
    check("z_rv", {30'd0, b_rvalid[d], a_rvalid[d]}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 2'b11;
    for (int d = 0; d < 2; d++) begin
      drive(d, 0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(d, 1, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero(0);
    check_zero(1);
    @(posedge clk); #1;
    rst = 2'b00;

    // single A write, then B reads it back
    do_req(0, 0, 1'b1, 8'h10, 8'hA5, 8'h00);
    do_req(0, 1, 1'b0, 8'h10, 8'h00, 8'hA5);
    // preload 0x20 for the overlap case
    do_req(0, 0, 1'b1, 8'h20, 8'h3C, 8'h00);
    repeat (2) @(posedge clk);

    // A read then B write arbitrated in A's rvalid cycle
    push_iss(0, 0, 1'b0, 8'h20, 8'h00);
    push_rd(0, 0, 8'h3C);
    push_iss(0, 1, 1'b1, 8'h30, 8'h77);
    @(posedge clk); #1;
    drive(0, 0, 1'b1, 1'b0, 8'h20, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("ovl_agnt", {31'd0, a_gnt[0]}, 1);
    @(posedge clk); #1;
    drive(0, 0, 1'b0, 1'b0, 8'h20, 8'h00);
    drive(0, 1, 1'b1, 1'b1, 8'h30, 8'h77);
    @(negedge clk);
    check("ovl_arv", {31'd0, a_rvalid[0]}, 1);
    check("ovl_ard", {24'd0, a_rdata[0]}, 8'h3C);
    check("ovl_bgnt0", {31'd0, b_gnt[0]}, 0);
    @(negedge clk);
    check("ovl_bgnt", {31'd0, b_gnt[0]}, 1);
    @(posedge clk); #1;
    drive(0, 1, 1'b0, 1'b1, 8'h30, 8'h77);
    repeat (3) @(posedge clk);

    // round-robin contention from reset: A,B,A,B
    #1;
    rst[0] = 1'b1;
    drive(0, 0, 1'b1, 1'b1, 8'h01, 8'h11);
    drive(0, 1, 1'b1, 1'b1, 8'h02, 8'h22);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push_iss(0, 0, 1'b1, 8'h01, 8'h11);
      else push_iss(0, 1, 1'b1, 8'h02, 8'h22);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    drive(0, 0, 1'b0, 1'b1, 8'h01, 8'h11);
    drive(0, 1, 1'b0, 1'b1, 8'h02, 8'h22);
    repeat (3) @(posedge clk);

    // fixed priority: A,A,A then B once A drops
    #1;
    rst[1] = 1'b1;
    drive(1, 0, 1'b1, 1'b1, 8'h41, 8'h5A);
    drive(1, 1, 1'b1, 1'b1, 8'h42, 8'h6B);
    for (int i = 0; i < 3; i++) push_iss(1, 0, 1'b1, 8'h41, 8'h5A);
    push_iss(1, 1, 1'b1, 8'h42, 8'h6B);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    drive(1, 0, 1'b0, 1'b1, 8'h41, 8'h5A);
    @(posedge clk);
    @(negedge clk);
    check("fx_bgnt", {31'd0, b_gnt[1]}, 1);
    @(posedge clk); #1;
    drive(1, 1, 1'b0, 1'b1, 8'h42, 8'h6B);
    repeat (3) @(posedge clk);

    // reset in the ISSUE cycle of an A read
    push_iss(0, 0, 1'b0, 8'h10, 8'h00);
    #1;
    drive(0, 0, 1'b1, 1'b0, 8'h10, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("rst_agnt", {31'd0, a_gnt[0]}, 1);
    rst[0] = 1'b1;
    drive(0, 0, 1'b0, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    check_zero(0);
    drive(0, 0, 1'b1, 1'b1, 8'h50, 8'h01);
    drive(0, 1, 1'b1, 1'b1, 8'h51, 8'h02);
    push_iss(0, 0, 1'b1, 8'h50, 8'h01);
    push_iss(0, 1, 1'b1, 8'h51, 8'h02);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_tie_a", {31'd0, a_gnt[0]}, 1);
    @(posedge clk); #1;
    drive(0, 0, 1'b0, 1'b1, 8'h50, 8'h01);
    @(posedge clk);
    @(negedge clk);
    check("rst_then_b", {31'd0, b_gnt[0]}, 1);
    @(posedge clk); #1;
    drive(0, 1, 1'b0, 1'b1, 8'h51, 8'h02);
    repeat (4) @(posedge clk);

    @(negedge clk);
    check("iss_left", iss_q.size(), 0);
    check("rd_left", rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
